// File: rtl/icache.sv
// icache: direct-mapped instruction cache with single-word lines and a newest-submit-wins fetch FSM.
module icache #(
  parameter int LINES = 16,
  localparam int IDX = $clog2(LINES),
  localparam int TW = 17 - IDX
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_req_addr,
  input  logic        i_req_ppl_submit,
  input  logic        i_page,
  input  logic        i_flush,
  output logic [31:0] o_req_data,
  output logic        o_req_data_valid,
  output logic        o_mem_req,
  output logic [15:0] o_mem_addr,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_ack
);
  typedef enum logic [1:0] {IDLE, LOOKUP, MISS, FILL_DROP} state_t;
  state_t state;
  logic [15:0] req_addr;
  logic req_page, fill_page;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [31:0] datas [LINES];
  logic [IDX-1:0] idx, fill_idx;
  logic hit, fill_done;
  assign idx = req_addr[IDX-1:0];
  assign fill_idx = o_mem_addr[IDX-1:0];
  // a flush in the lookup cycle forces a miss
  assign hit = valid[idx] && tags[idx] == {req_page, req_addr[15:IDX]} && !i_flush;
  assign fill_done = (state == MISS || state == FILL_DROP) && i_mem_ack;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      req_addr <= '0;
      req_page <= 1'b0;
      fill_page <= 1'b0;
      valid <= '0;
      o_req_data <= '0;
      o_req_data_valid <= 1'b0;
      o_mem_req <= 1'b0;
      o_mem_addr <= '0;
    end else begin
      o_req_data_valid <= 1'b0;
      if (i_req_ppl_submit) begin
        req_addr <= i_req_addr;
        req_page <= i_page;
      end
      if (i_flush) valid <= '0;
      else if (fill_done) valid[fill_idx] <= 1'b1;
      case (state)
        IDLE: state <= i_req_ppl_submit ? LOOKUP : IDLE;
        LOOKUP:
          if (i_req_ppl_submit) state <= LOOKUP;
          else if (hit) begin
            o_req_data_valid <= 1'b1;
            o_req_data <= datas[idx];
            state <= IDLE;
          end else begin
            o_mem_req <= 1'b1;
            o_mem_addr <= req_addr;
            fill_page <= req_page;
            state <= MISS;
          end
        MISS:
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            state <= i_req_ppl_submit ? LOOKUP : IDLE;
            if (!i_req_ppl_submit) begin
              o_req_data_valid <= 1'b1;
              o_req_data <= i_mem_data;
            end
          end else if (i_req_ppl_submit) state <= FILL_DROP;
        FILL_DROP:
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            state <= LOOKUP;
          end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk)
    if (fill_done) begin
      tags[fill_idx] <= {fill_page, o_mem_addr[15:IDX]};
      datas[fill_idx] <= i_mem_data;
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: table-driven hit/miss vectors plus hand-written supersede, flush and reset sequences.
module tb_icache;
  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] req_addr = '0;
  logic submit = 1'b0, page = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic [31:0] req_data;
  logic req_valid, mem_req;
  logic [15:0] mem_addr;
  int checks = 0, errors = 0;

  icache #(.LINES(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_addr(req_addr), .i_req_ppl_submit(submit),
    .i_page(page), .i_flush(flush), .o_req_data(req_data), .o_req_data_valid(req_valid),
    .o_mem_req(mem_req), .o_mem_addr(mem_addr), .i_mem_data(mem_data), .i_mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic page;
    logic miss;
    logic [31:0] fill;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_submit(input logic [15:0] a, input logic p);
    req_addr = a;
    page = p;
    submit = 1'b1;
    tick();
    submit = 1'b0;
  endtask

  task automatic do_ack(input logic [31:0] d, input logic f);
    mem_data = d;
    mem_ack = 1'b1;
    flush = f;
    tick();
    mem_ack = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    vecs[0] = '{16'h0010, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[1] = '{16'h0010, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF};
    vecs[2] = '{16'h0020, 1'b0, 1'b1, 32'h11112222, 32'h11112222};
    vecs[3] = '{16'h0010, 1'b0, 1'b1, 32'h0BADF00D, 32'h0BADF00D};
    vecs[4] = '{16'h0010, 1'b0, 1'b0, 32'h0, 32'h0BADF00D};
    vecs[5] = '{16'h0025, 1'b0, 1'b1, 32'h55555555, 32'h55555555};
    vecs[6] = '{16'h0025, 1'b1, 1'b1, 32'hAAAA0001, 32'hAAAA0001};
    vecs[7] = '{16'h0025, 1'b1, 1'b0, 32'h0, 32'hAAAA0001};
    vecs[8] = '{16'h0010, 1'b0, 1'b0, 32'h0, 32'h0BADF00D};
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_data", req_data, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 32'h0);
    for (int i = 0; i < 9; i++) begin
      do_submit(vecs[i].addr, vecs[i].page);
      tick();
      if (vecs[i].miss) begin
        chk($sformatf("v%0d_mem_req", i), {31'b0, mem_req}, 32'h1);
        chk($sformatf("v%0d_mem_addr", i), {16'b0, mem_addr}, {16'b0, vecs[i].addr});
        chk($sformatf("v%0d_early_valid", i), {31'b0, req_valid}, 32'h0);
        do_ack(vecs[i].fill, 1'b0);
      end else chk($sformatf("v%0d_hit_no_mem", i), {31'b0, mem_req}, 32'h0);
      chk($sformatf("v%0d_valid", i), {31'b0, req_valid}, 32'h1);
      chk($sformatf("v%0d_data", i), req_data, vecs[i].exp);
      chk($sformatf("v%0d_mem_req_low", i), {31'b0, mem_req}, 32'h0);
      tick();
      chk($sformatf("v%0d_pulse_end", i), {31'b0, req_valid}, 32'h0);
    end
    // superseding submit during an outstanding miss
    flush = 1'b1;
    tick();
    flush = 1'b0;
    do_submit(16'h0010, 1'b0);
    tick();
    chk("sup_mem_req", {31'b0, mem_req}, 32'h1);
    do_submit(16'h0031, 1'b0);
    chk("sup_addr_held", {16'b0, mem_addr}, 32'h0010);
    chk("sup_req_held", {31'b0, mem_req}, 32'h1);
    do_ack(32'h12345678, 1'b0);
    chk("sup_drop_valid", {31'b0, req_valid}, 32'h0);
    chk("sup_drop_mem_req", {31'b0, mem_req}, 32'h0);
    tick();
    chk("sup_new_mem_req", {31'b0, mem_req}, 32'h1);
    chk("sup_new_mem_addr", {16'b0, mem_addr}, 32'h0031);
    chk("sup_new_no_valid", {31'b0, req_valid}, 32'h0);
    do_ack(32'hCAFEF00D, 1'b0);
    chk("sup_valid", {31'b0, req_valid}, 32'h1);
    chk("sup_data", req_data, 32'hCAFEF00D);
    tick();
    chk("sup_single_pulse", {31'b0, req_valid}, 32'h0);
    do_submit(16'h0010, 1'b0);
    tick();
    chk("drop_fill_hit", {31'b0, req_valid}, 32'h1);
    chk("drop_fill_data", req_data, 32'h12345678);
    chk("drop_fill_no_mem", {31'b0, mem_req}, 32'h0);
    tick();
    // page mismatch miss, flush coinciding with ack
    do_submit(16'h0010, 1'b1);
    tick();
    chk("pg_miss", {31'b0, mem_req}, 32'h1);
    do_ack(32'h77778888, 1'b1);
    chk("flush_ack_valid", {31'b0, req_valid}, 32'h1);
    chk("flush_ack_data", req_data, 32'h77778888);
    tick();
    do_submit(16'h0010, 1'b1);
    tick();
    chk("flush_refill_miss", {31'b0, mem_req}, 32'h1);
    do_ack(32'h0000CAFE, 1'b0);
    chk("flush_refill_data", req_data, 32'h0000CAFE);
    tick();
    // back-to-back submits in LOOKUP give one pulse
    do_submit(16'h0031, 1'b0);
    tick();
    do_ack(32'hCAFEF00D, 1'b0);
    tick();
    do_submit(16'h0031, 1'b0);
    do_submit(16'h0031, 1'b0);
    chk("dbl_no_pulse", {31'b0, req_valid}, 32'h0);
    tick();
    chk("dbl_valid", {31'b0, req_valid}, 32'h1);
    chk("dbl_data", req_data, 32'hCAFEF00D);
    tick();
    chk("dbl_pulse_end", {31'b0, req_valid}, 32'h0);
    // stray ack in IDLE ignored, data holds
    do_ack(32'hFFFFFFFF, 1'b0);
    chk("stray_ack_valid", {31'b0, req_valid}, 32'h0);
    chk("hold_data", req_data, 32'hCAFEF00D);
    // flush during lookup forces a miss
    req_addr = 16'h0031;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_lookup_miss", {31'b0, mem_req}, 32'h1);
    chk("flush_lookup_no_valid", {31'b0, req_valid}, 32'h0);
    do_ack(32'h31313131, 1'b0);
    chk("flush_lookup_data", req_data, 32'h31313131);
    tick();
    // reset mid-refill
    do_submit(16'h0044, 1'b0);
    tick();
    chk("rm_mem_req", {31'b0, mem_req}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_req_drop", {31'b0, mem_req}, 32'h0);
    chk("rm_addr_zero", {16'b0, mem_addr}, 32'h0);
    chk("rm_data_zero", req_data, 32'h0);
    do_ack(32'h99999999, 1'b0);
    chk("rm_late_ack", {31'b0, req_valid}, 32'h0);
    chk("rm_late_data", req_data, 32'h0);
    do_submit(16'h0031, 1'b0);
    tick();
    chk("rm_invalidated", {31'b0, mem_req}, 32'h1);
    do_ack(32'h0, 1'b0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: LINES, 16, number of direct-mapped lines (power of two, 2..256); IDX = log2(LINES).
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_req_addr  input  16  instruction word address from core fetch.
REQ-005 i_req_ppl_submit  input  1  one-cycle pulse: new fetch address valid on i_req_addr.
REQ-006 i_page  input  1  current instruction page (core o_c_instr_page); part of tag.
REQ-007 i_flush  input  1  one-cycle pulse: invalidate all lines.
REQ-008 o_req_data  output  32  instruction returned to fetch.
REQ-009 o_req_data_valid  output  1  one-cycle pulse: o_req_data is response to newest accepted submit.
REQ-010 o_mem_req  output  1  refill request to instruction memory; held until ack.
REQ-011 o_mem_addr  output  16  refill word address; stable while o_mem_req high.
REQ-012 i_mem_data  input  32  refill data, valid with i_mem_ack.
REQ-013 i_mem_ack  input  1  one-cycle pulse completing refill.

Function
REQ-014 Address split: index = i_req_addr[IDX-1:0]; tag = {i_page, i_req_addr[15:IDX]}; per line: valid bit, tag, 32-bit data.
REQ-015 States: IDLE, LOOKUP, MISS, FILL_DROP.
REQ-016 Submit accepted in every state; address and page latched into req register; newest submit always wins.
REQ-017 IDLE + submit -> LOOKUP.
REQ-018 LOOKUP, hit (valid and tag equal): o_req_data_valid=1 and o_req_data=line data next cycle; -> IDLE (or LOOKUP if new submit same cycle, no valid pulse for old address).
REQ-019 Hit latency: submit at cycle T -> o_req_data_valid at T+2.
REQ-020 LOOKUP, miss: o_mem_req=1, o_mem_addr=latched address from next cycle; -> MISS.
REQ-021 MISS + i_mem_ack, no pending submit: write line (valid=1, tag, data); o_req_data_valid=1, o_req_data=i_mem_data next cycle; o_mem_req=0 next cycle; -> IDLE.
REQ-022 Submit during MISS: bus transaction not aborted, o_mem_addr unchanged; -> FILL_DROP; on ack line still written, no valid pulse; then -> LOOKUP for newest address.
REQ-023 Submit in same cycle as i_mem_ack: treated as REQ-022 (fill written, no pulse, -> LOOKUP).
REQ-024 o_req_data_valid never high for more than one consecutive cycle per accepted submit; never high for superseded address.
REQ-025 i_flush: all valid bits cleared next cycle; in-flight refill completing same cycle as flush is NOT marked valid (flush wins); a completing miss still delivers its data pulse.
REQ-026 Flush in LOOKUP: lookup treats line as invalid (miss).
REQ-027 o_req_data holds last value when o_req_data_valid=0.
REQ-028 i_mem_ack outside MISS/FILL_DROP ignored.

Reset
REQ-029 On i_rst: state IDLE; all valid bits 0; o_req_data_valid=0; o_mem_req=0; o_mem_addr=0; o_req_data=0; req register 0.
REQ-030 Reset mid-refill: o_mem_req drops next cycle; late i_mem_ack after reset ignored (REQ-028).

Verification
REQ-031 Reset, submit 0x0010 page 0 -> o_mem_req=1, o_mem_addr=0x0010 at T+2; ack 0xDEADBEEF -> one valid pulse, data 0xDEADBEEF.
REQ-032 Resubmit 0x0010 -> valid at T+2 with 0xDEADBEEF, o_mem_req stays 0.
REQ-033 LINES=16: submit 0x0020 (same index) -> miss, fill 0x11112222; resubmit 0x0010 -> miss again.
REQ-034 Submit 0x0031 while 0x0010 miss outstanding -> ack 0x0010 yields no pulse; then o_mem_addr=0x0031, ack 0xCAFEF00D -> single pulse 0xCAFEF00D.
REQ-035 Fill 0x0010 page 0, submit 0x0010 page 1 -> miss; i_flush with ack -> data pulse, then resubmit misses.
